monitor_demux_14: RTL and testbench

- Return path from the shared hardware monitor back to the 4 network-processor cores. This is the 1-to-4 counterpart of the core-to-monitor select mux.
- Takes the monitor's alarm verdict and attributes it to the core that was selected when the monitored instruction was issued. It realigns `sel` to the verdict through a pipeline that matches the monitor latency.
- Per core, it drives a stretched reset request and a sticky alarm flag, held until the core acknowledges. It also keeps a saturating per-core alarm counter for the control plane.

---
 rtl/ngnp_monitor_pkg.sv | 15 +
 rtl/core_alarm_ctrl.sv | 85 ++++++++
 rtl/monitor_demux_14.sv | 84 ++++++++
 tb/tb_monitor_demux_14.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ngnp_monitor_pkg.sv
// Shared definitions for the network-processor hardware monitor return path.
package ngnp_monitor_pkg;

  localparam int NUM_CORES            = 4;
  localparam int CORE_W               = 2;
  localparam int DEFAULT_MON_LATENCY  = 1;
  localparam int DEFAULT_RESET_CYCLES = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_ACK = 2'd2
  } alarm_state_t;

endpackage

// File: rtl/core_alarm_ctrl.sv
// Per-core alarm handler: stretched reset request, sticky alarm until
// acknowledged, and a saturating alarm counter for the control plane.
module core_alarm_ctrl
  import ngnp_monitor_pkg::*;
#(
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hit,
  input  logic             ack,
  input  logic             clr_counts,
  output logic             alarm,
  output logic             reset_req,
  output logic [CNT_W-1:0] count
);

  // Timer counts down the remaining HOLD cycles after the current one.
  localparam logic [7:0] TIMER_LOAD = 8'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] COUNT_MAX = '1;

  alarm_state_t state, state_next;
  logic [7:0]   timer, timer_next;

  // Next-state logic: a new hit always wins over an acknowledge in WAIT_ACK.
  always_comb begin
    state_next = state;
    timer_next = timer;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_next = HOLD;
          timer_next = TIMER_LOAD;
        end
      end
      HOLD: begin
        if (timer == 8'd0) begin
          state_next = WAIT_ACK;
        end else begin
          timer_next = timer - 8'd1;
        end
      end
      WAIT_ACK: begin
        if (hit) begin
          state_next = HOLD;
          timer_next = TIMER_LOAD;
        end else if (ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = 8'd0;
      end
    endcase
  end

  // State register; outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= 8'd0;
      alarm     <= 1'b0;
      reset_req <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      alarm     <= (state_next != IDLE);
      reset_req <= (state_next == HOLD);
    end
  end

  // Saturating alarm counter; a clear coinciding with a hit leaves a count of one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr_counts) begin
      count <= hit ? CNT_W'(1) : '0;
    end else if (hit && (count != COUNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/monitor_demux_14.sv
// Return path from the shared monitor: realigns the core select with the
// monitor verdict and dispatches the alarm to the per-core handlers.
module monitor_demux_14
  import ngnp_monitor_pkg::*;
#(
  parameter int MON_LATENCY  = DEFAULT_MON_LATENCY,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int CNT_W        = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [CORE_W-1:0]          sel,
  input  logic                       mon_alarm,
  input  logic [NUM_CORES-1:0]       core_ack,
  input  logic                       clr_counts,
  output logic [NUM_CORES-1:0]       core_alarm,
  output logic [NUM_CORES-1:0]       core_reset_req,
  output logic [NUM_CORES*CNT_W-1:0] alarm_count,
  output logic                       any_alarm
);

  logic                 attr_valid;
  logic [CORE_W-1:0]    attr_core;
  logic [NUM_CORES-1:0] hit;

  generate
    if (MON_LATENCY == 0) begin : g_no_pipe
      assign attr_valid = 1'b1;
      assign attr_core  = sel;
    end else begin : g_pipe
      logic [MON_LATENCY-1:0] pipe_valid;
      logic [CORE_W-1:0]      pipe_sel [MON_LATENCY];

      // Delay the select by the monitor latency; valid bits mask the post-reset window.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < MON_LATENCY; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_sel[i]   <= '0;
          end
        end else begin
          pipe_valid[0] <= 1'b1;
          pipe_sel[0]   <= sel;
          for (int i = 1; i < MON_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_sel[i]   <= pipe_sel[i-1];
          end
        end
      end

      assign attr_valid = pipe_valid[MON_LATENCY-1];
      assign attr_core  = pipe_sel[MON_LATENCY-1];
    end
  endgenerate

  // One-hot hit decode toward the core that was selected when the verdict's instruction issued.
  always_comb begin
    hit = '0;
    if (mon_alarm && attr_valid) begin
      hit[attr_core] = 1'b1;
    end
  end

  generate
    for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
      core_alarm_ctrl #(
        .RESET_CYCLES(RESET_CYCLES),
        .CNT_W       (CNT_W)
      ) u_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .hit       (hit[c]),
        .ack       (core_ack[c]),
        .clr_counts(clr_counts),
        .alarm     (core_alarm[c]),
        .reset_req (core_reset_req[c]),
        .count     (alarm_count[c*CNT_W +: CNT_W])
      );
    end
  endgenerate

  assign any_alarm = |core_alarm;

endmodule

// File: tb/tb_monitor_demux_14.sv
// Randomized and directed bench for monitor_demux_14 against a cycle-level
// behavioural model built from the alarm attribution rules.
module tb_monitor_demux_14;

  localparam int L     = 1;
  localparam int RC    = 8;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  sel;
  logic        mon_alarm;
  logic [3:0]  core_ack;
  logic        clr_counts;
  logic [3:0]  core_alarm;
  logic [3:0]  core_reset_req;
  logic [31:0] alarm_count;
  logic        any_alarm;

  int checks = 0;
  int errors = 0;

  // Model state: past selects, sticky flag, remaining request cycles, counts.
  int q_sel[$];
  bit m_alarm[4];
  int m_req_left[4];
  int m_count[4];

  monitor_demux_14 #(
    .MON_LATENCY (L),
    .RESET_CYCLES(RC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sel           (sel),
    .mon_alarm     (mon_alarm),
    .core_ack      (core_ack),
    .clr_counts    (clr_counts),
    .core_alarm    (core_alarm),
    .core_reset_req(core_reset_req),
    .alarm_count   (alarm_count),
    .any_alarm     (any_alarm)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input bit rst_v, input int sel_v, input bit alarm_v,
                           input logic [3:0] ack_v, input bit clr_v);
    int h;
    if (!rst_v) begin
      q_sel.delete();
      for (int i = 0; i < 4; i++) begin
        m_alarm[i] = 0; m_req_left[i] = 0; m_count[i] = 0;
      end
    end else begin
      h = -1;
      if (alarm_v) begin
        if (L == 0) h = sel_v;
        else if (q_sel.size() >= L) h = q_sel[q_sel.size() - L];
      end
      for (int i = 0; i < 4; i++) begin
        if (clr_v) m_count[i] = (h == i) ? 1 : 0;
        else if (h == i && m_count[i] < CMAX) m_count[i]++;
        if (m_req_left[i] > 0) begin
          m_req_left[i]--;
        end else if (m_alarm[i]) begin
          if (h == i) m_req_left[i] = RC;
          else if (ack_v[i]) m_alarm[i] = 0;
        end else if (h == i) begin
          m_alarm[i] = 1;
          m_req_left[i] = RC;
        end
      end
      if (L > 0) begin
        q_sel.push_back(sel_v);
        while (q_sel.size() > L) void'(q_sel.pop_front());
      end
    end
  endtask

  task automatic compareAll();
    logic [3:0]  exp_alarm, exp_req;
    logic [31:0] exp_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_alarm[i] = m_alarm[i];
      exp_req[i]   = (m_req_left[i] > 0);
      exp_cnt[i*8 +: 8] = 8'(m_count[i]);
    end
    checkOutput("core_alarm", 32'(core_alarm), 32'(exp_alarm));
    checkOutput("core_reset_req", 32'(core_reset_req), 32'(exp_req));
    checkOutput("alarm_count", alarm_count, exp_cnt);
    checkOutput("any_alarm", 32'(any_alarm), 32'(|exp_alarm));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare just after it.
  task automatic applyStimulus(input bit rst_v, input int sel_v, input bit alarm_v,
                               input logic [3:0] ack_v, input bit clr_v);
    reset_n    = rst_v;
    sel        = 2'(sel_v);
    mon_alarm  = alarm_v;
    core_ack   = ack_v;
    clr_counts = clr_v;
    @(posedge clk);
    modelStep(rst_v, sel_v, alarm_v, ack_v, clr_v);
    #1;
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1, $urandom_range(0, 3), 0, 4'b0, 0);
  endtask

  initial begin
    reset_n = 1'b0; sel = 2'd0; mon_alarm = 1'b0; core_ack = 4'b0; clr_counts = 1'b0;
    #2;
    applyStimulus(0, 0, 0, 4'b0, 0);
    applyStimulus(0, 1, 1, 4'b1111, 0);

    // Attribution: core 2 selected one cycle before the verdict.
    idleCycles(8);
    applyStimulus(1, 2, 0, 4'b0, 0);
    applyStimulus(1, 0, 1, 4'b0, 0);
    idleCycles(12);

    // Ack core 2 in WAIT_ACK; ack on idle core 1 is harmless.
    applyStimulus(1, 1, 0, 4'b0110, 0);
    idleCycles(2);

    // Second hit on core 3 late in HOLD does not restart the request.
    applyStimulus(1, 3, 0, 4'b0, 0);
    applyStimulus(1, 0, 1, 4'b0, 0);
    idleCycles(3);
    applyStimulus(1, 3, 0, 4'b0, 0);
    applyStimulus(1, 0, 1, 4'b0, 0);
    idleCycles(12);
    applyStimulus(1, 0, 0, 4'b1000, 0);

    // Core 0: hit plus ack in WAIT_ACK re-enters HOLD.
    applyStimulus(1, 0, 0, 4'b0, 0);
    applyStimulus(1, 0, 1, 4'b0, 0);
    idleCycles(10);
    applyStimulus(1, 0, 0, 4'b0, 0);
    applyStimulus(1, 1, 1, 4'b0001, 0);
    idleCycles(10);
    applyStimulus(1, 1, 0, 4'b0001, 0);

    // 260 hits on core 1 saturate, then clear with a coincident hit.
    for (int k = 0; k < 261; k++) applyStimulus(1, 1, (k > 0), 4'b0, 0);
    applyStimulus(1, 1, 1, 4'b0, 1);
    idleCycles(10);
    applyStimulus(1, 0, 0, 4'b1111, 0);

    // Reset during HOLD, then a verdict on the first cycle after reset is dropped.
    applyStimulus(1, 2, 0, 4'b0, 0);
    applyStimulus(1, 2, 1, 4'b0, 0);
    idleCycles(3);
    applyStimulus(0, 2, 0, 4'b0, 0);
    applyStimulus(1, 2, 1, 4'b0, 0);
    idleCycles(3);

    // Randomized traffic with occasional clears and resets.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 199) != 0), $urandom_range(0, 3),
                    ($urandom_range(0, 5) == 0),
                    4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
                    ($urandom_range(0, 29) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
